// File: rtl/spi_phase_rx.sv
// SPI frame receiver: oversamples mclk/ss_n/miso in the clk domain and buffers whole words in a FIFO.
// Optional statistics counters are enabled with `define SPI_PHASE_RX_STATS_EN.
module spi_phase_rx #(
  parameter int DATA_LENGTH = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mclk,
  input  logic                   ss_n,
  input  logic                   miso,
  output logic [DATA_LENGTH-1:0] data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic [7:0]             phase_out,
  output logic                   frame_err,
`ifdef SPI_PHASE_RX_STATS_EN
  output logic                   overflow,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            err_cnt
`else
  output logic                   overflow
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_LENGTH + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] mclk_sync, ss_sync, miso_sync, fill;
  logic                   mclk_prev, ss_prev, armed;
  logic                   mclk_s, ss_s, miso_s, settled;
  logic                   mclk_rise, ss_rise, ss_fall;

  logic [DATA_LENGTH-1:0] shreg;
  logic [CW-1:0]          bit_cnt;
  logic                   frame_ok;

  logic [DATA_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic [DATA_LENGTH-1:0] held;
  logic                   empty, full, push, pop;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_sync <= '1;
      ss_sync   <= '1;
      miso_sync <= '1;
      fill      <= '0;
    end else begin
      mclk_sync[0] <= mclk;
      ss_sync[0]   <= ss_n;
      miso_sync[0] <= miso;
      fill[0]      <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mclk_sync[i] <= mclk_sync[i-1];
        ss_sync[i]   <= ss_sync[i-1];
        miso_sync[i] <= miso_sync[i-1];
        fill[i]      <= fill[i-1];
      end
    end
  end

  assign mclk_s  = mclk_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign miso_s  = miso_sync[SYNC_STAGES-1];
  assign settled = fill[SYNC_STAGES-1];

  // A frame may only start after ss_n has been genuinely seen high since reset;
  // the synchronizers' reset value of 1 must not count as that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclk_prev <= 1'b1;
      ss_prev   <= 1'b1;
      armed     <= 1'b0;
    end else begin
      mclk_prev <= mclk_s;
      ss_prev   <= ss_s;
      if (settled && ss_s) armed <= 1'b1;
    end
  end

  assign mclk_rise = mclk_s & ~mclk_prev;
  assign ss_rise   = ss_s & ~ss_prev;
  assign ss_fall   = armed & ss_prev & ~ss_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ss_fall) next_state = SHIFT;
      SHIFT:   if (ss_rise) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign frame_ok = (bit_cnt == CW'(DATA_LENGTH));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    push      = 1'b0;
    overflow  = 1'b0;
    frame_err = 1'b0;
    if (state == DONE) begin
      if (!frame_ok)         frame_err = 1'b1;
      else if (!full || pop) push      = 1'b1;
      else                   overflow  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE && ss_fall) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state == SHIFT && !ss_rise && mclk_rise) begin
      shreg <= {shreg[DATA_LENGTH-2:0], miso_s};
      if (bit_cnt != CW'(DATA_LENGTH + 1)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_valid = ~empty;
  assign pop        = data_valid & data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      held   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        held   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // NOTE: the storage array has no reset; it is never visible before being written,
  // because data_out shows the reset-cleared held word whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign data_out  = data_valid ? mem[rd_ptr[AW-1:0]] : held;
  assign phase_out = data_out[7:0];

`ifdef SPI_PHASE_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (push) frame_cnt <= frame_cnt + 16'd1;
      err_cnt <= err_cnt + 16'(frame_err) + 16'(overflow);
    end
  end
`endif

endmodule

// File: tb/tb_spi_phase_rx.sv
// Directed bench for spi_phase_rx: a word-level queue model is compared with the outputs every cycle,
// and each scenario ends with hand-computed literal expectations.
module tb_spi_phase_rx;
  localparam int DL    = 16;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int HALF  = 4;   // clk cycles per mclk half period (8x oversampling)

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mclk = 1'b0;
  logic          ss_n = 1'b1;
  logic          miso = 1'b0;
  logic          data_ready = 1'b0;
  logic [DL-1:0] data_out;
  logic          data_valid;
  logic [7:0]    phase_out;
  logic          frame_err;
  logic          overflow;
`ifdef SPI_PHASE_RX_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;
`endif

  spi_phase_rx #(.DATA_LENGTH(DL), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mclk       (mclk),
    .ss_n       (ss_n),
    .miso       (miso),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .phase_out  (phase_out),
    .frame_err  (frame_err),
`ifdef SPI_PHASE_RX_STATS_EN
    .overflow   (overflow),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
`else
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Word-level model: words expected in the FIFO, outstanding pulses, last word handed out.
  logic [DL-1:0] exp_q[$];
  logic [DL-1:0] exp_last = '0;
  int            exp_ferr = 0;
  int            exp_ovf  = 0;
  int            seen_ferr = 0;
  int            seen_ovf  = 0;
  logic [DL-1:0] popped[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_frame(input logic [DL-1:0] v, input int nbits, input bit coincident_pop);
    if (nbits != DL)                                 exp_ferr++;
    else if (exp_q.size() >= DEPTH && !coincident_pop) exp_ovf++;
    else                                             exp_q.push_back(v);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_last = '0;
    exp_ferr = 0;
    exp_ovf  = 0;
  endtask

  task automatic clear_obs();
    popped.delete();
    seen_ferr = 0;
    seen_ovf  = 0;
  endtask

  // Compare process: sampled 2 time units after each falling edge, far from the rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          check("valid_without_expected_word", data_valid, 1'b0);
        end else begin
          check("data_out_head", data_out, exp_q[0]);
          check("phase_out_head", phase_out, exp_q[0][7:0]);
          if (data_ready) begin
            exp_last = exp_q.pop_front();
            popped.push_back(data_out);
          end
        end
      end else begin
        check("data_out_held", data_out, exp_last);
        check("phase_out_held", phase_out, exp_last[7:0]);
      end
      if (frame_err) begin
        seen_ferr++;
        if (exp_ferr == 0) check("frame_err_unexpected", frame_err, 1'b0);
        else               exp_ferr--;
      end
      if (overflow) begin
        seen_ovf++;
        if (exp_ovf == 0) check("overflow_unexpected", overflow, 1'b0);
        else              exp_ovf--;
      end
    end
  end

  task automatic mclk_pulses(input logic [31:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      miso = val[i];
      mclk = 1'b0;
      repeat (HALF) @(negedge clk);
      mclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    mclk = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // coincident_pop raises data_ready for exactly the cycle in which the frame completes:
  // SYNC cycles through the synchronizer, one for edge detection, then the completion cycle.
  task automatic send_frame(input logic [31:0] val, input int nbits, input bit coincident_pop);
    @(negedge clk);
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    mclk_pulses(val, nbits);
    ss_n = 1'b1;
    model_frame(val[DL-1:0], nbits, coincident_pop);
    if (coincident_pop) begin
      repeat (SYNC + 1) @(negedge clk);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 200;
    data_ready = 1'b1;
    while ((exp_q.size() != 0 || data_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (2) @(negedge clk);
    data_ready = 1'b0;
    check({name, "_drain_left"}, exp_q.size(), 0);
    check({name, "_missing_frame_err"}, exp_ferr, 0);
    check({name, "_missing_overflow"}, exp_ovf, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("reset_data_valid", data_valid, 1'b0);
    check("reset_data_out", data_out, 16'h0000);
    check("reset_phase_out", phase_out, 8'h00);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single frame 0xA53C with consumer always ready
    clear_obs();
    data_ready = 1'b1;
    send_frame(32'hA53C, DL, 1'b0);
    drain("a53c");
    check("a53c_pop_count", popped.size(), 1);
    check("a53c_word", popped[0], 16'hA53C);
    check("a53c_phase", phase_out, 8'h3C);
    check("a53c_frame_err", seen_ferr, 0);

    // Five frames with the consumer stalled: four held, fifth overflows
    clear_obs();
    for (int k = 1; k <= 5; k++) send_frame(32'(k), DL, 1'b0);
    check("fill_overflow_pulses", seen_ovf, 1);
    check("fill_head_word", data_out, 16'h0001);
    check("fill_valid", data_valid, 1'b1);
    drain("fill");
    check("fill_pop_count", popped.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("fill_pop_%0d", k), popped[k], 32'(k + 1));

    // Short and long frames
    clear_obs();
    send_frame(32'h7FFF, DL - 1, 1'b0);
    send_frame(32'h1FFFF, DL + 1, 1'b0);
    check("badlen_frame_err_pulses", seen_ferr, 2);
    check("badlen_valid", data_valid, 1'b0);
    drain("badlen");
    check("badlen_pop_count", popped.size(), 0);

    // Full FIFO, frame completes in the same cycle as a pop
    clear_obs();
    send_frame(32'h0011, DL, 1'b0);
    send_frame(32'h0022, DL, 1'b0);
    send_frame(32'h0033, DL, 1'b0);
    send_frame(32'h0044, DL, 1'b0);
    send_frame(32'h1234, DL, 1'b1);
    check("simul_overflow_pulses", seen_ovf, 0);
    drain("simul");
    check("simul_pop_count", popped.size(), 5);
    check("simul_first_pop", popped[0], 16'h0011);
    check("simul_fourth_after_pop", popped[4], 16'h1234);

    // Reset in mid-frame with ss_n still low at release, then a clean frame
    clear_obs();
    @(negedge clk);
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
    mclk_pulses(32'hAB, 8);
    rst_n = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    #2;
    check("midreset_valid", data_valid, 1'b0);
    check("midreset_data_out", data_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    mclk_pulses(32'hF, 4);
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    data_ready = 1'b1;
    send_frame(32'hFFFF, DL, 1'b0);
    drain("midreset");
    check("midreset_pop_count", popped.size(), 1);
    check("midreset_word", popped[0], 16'hFFFF);
    check("midreset_frame_err", seen_ferr, 0);
`ifdef SPI_PHASE_RX_STATS_EN
    check("midreset_frame_cnt", frame_cnt, 16'd1);
    check("midreset_err_cnt", err_cnt, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
